// File: rtl/tcm_boot_loader.sv
// tcm_boot_loader: streams a byte image into the TCM data port as 32-bit
// little-endian word writes and holds the core in reset until every write
// has been acknowledged.
// Optional build macro: TCM_LOADER_CHECKSUM_EN adds checksum_o, the wrapping
// 32-bit sum of every issued write word (unfilled lanes count as zero).

// One byte lane of the packing register: captures a byte and marks it filled.
module tcm_boot_loader_lane #(
  parameter int VEC_W = 8
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             clr_i,
  input  logic             load_i,
  input  logic [VEC_W-1:0] byte_i,
  output logic [VEC_W-1:0] byte_o,
  output logic             fill_o
);

  // Lane storage; clear wins so an accepted word leaves all lanes empty.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      byte_o <= '0;
      fill_o <= 1'b0;
    end else if (clr_i) begin
      byte_o <= '0;
      fill_o <= 1'b0;
    end else if (load_i) begin
      byte_o <= byte_i;
      fill_o <= 1'b1;
    end
  end

endmodule

module tcm_boot_loader #(
  parameter logic [31:0] BASE_ADDR       = 32'h0000_0000,
  parameter int unsigned MAX_BYTES       = 65536,
  parameter int unsigned MAX_OUTSTANDING = 4
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        start_i,
  input  logic        in_valid_i,
  input  logic [7:0]  in_data_i,
  input  logic        in_last_i,
  output logic        in_ready_o,
  output logic [31:0] mem_d_addr_o,
  output logic [31:0] mem_d_data_wr_o,
  output logic [3:0]  mem_d_wr_o,
  output logic        mem_d_rd_o,
  output logic [10:0] mem_d_req_tag_o,
  output logic        mem_d_cacheable_o,
  output logic        mem_d_invalidate_o,
  output logic        mem_d_writeback_o,
  output logic        mem_d_flush_o,
  input  logic        mem_d_accept_i,
  input  logic        mem_d_ack_i,
  input  logic        mem_d_error_i,
  output logic        core_rst_o,
  output logic        busy_o,
  output logic        done_o,
  output logic        error_o,
  output logic [16:0] byte_count_o
`ifdef TCM_LOADER_CHECKSUM_EN
  ,
  output logic [31:0] checksum_o
`endif
);

  localparam int NUM_LANES = 4;
  localparam int VEC_W     = 8;
  localparam int LW        = $clog2(NUM_LANES);
  localparam int OW        = $clog2(MAX_OUTSTANDING + 1);
  localparam logic [16:0]   CAP     = 17'(MAX_BYTES);
  localparam logic [OW-1:0] OUT_MAX = OW'(MAX_OUTSTANDING);

  typedef enum logic [2:0] {
    S_IDLE, S_COLLECT, S_WRITE, S_DRAIN, S_DONE, S_ERROR
  } state_t;

  typedef struct packed {
    logic [31:0]                       addr;
    logic [NUM_LANES-1:0][VEC_W-1:0]   data;
    logic [NUM_LANES-1:0]              mask;
  } wr_req_t;

  state_t state_q, state_d;

  logic [16:0]   cnt_q;
  logic [31:0]   addr_q;
  logic [OW-1:0] out_q, out_step;
  logic          last_q, ovf_q, berr_q;

  logic [NUM_LANES-1:0][VEC_W-1:0] lane_byte;
  logic [NUM_LANES-1:0]            lane_fill;
  logic [NUM_LANES-1:0]            lane_ld;
  logic                            lane_clr;
  logic [LW-1:0]                   lane_sel;

  logic    start_ok, hs, at_cap, take, drop, word_end;
  logic    stall, req, acc, ack_v, berr_ev;
  wr_req_t wr_req;

  assign start_ok = start_i && (state_q == S_IDLE || state_q == S_DONE ||
                                state_q == S_ERROR);
  assign in_ready_o = (state_q == S_COLLECT);
  assign hs       = in_ready_o && in_valid_i;
  assign at_cap   = (cnt_q == CAP);
  assign take     = hs && !at_cap;
  assign drop     = hs && at_cap;
  assign lane_sel = cnt_q[LW-1:0];
  // A word closes on its top lane, on the image's last byte, or when the
  // capacity is reached so that no later byte can land in a stale word.
  assign word_end = take && (lane_sel == LW'(NUM_LANES - 1) || in_last_i ||
                             (cnt_q + 17'd1 == CAP));

  assign stall   = (out_q == OUT_MAX);
  assign req     = (state_q == S_WRITE) && !stall;
  assign acc     = req && mem_d_accept_i;
  assign ack_v   = mem_d_ack_i && (out_q != '0);
  assign berr_ev = ack_v && mem_d_error_i;
  assign out_step = out_q + OW'(acc) - OW'(ack_v);

  assign lane_clr = start_ok || acc;

  for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
    assign lane_ld[i] = take && (lane_sel == LW'(i));
    tcm_boot_loader_lane #(.VEC_W(VEC_W)) u_lane (
      .clk_i  (clk_i),
      .rst_ni (rst_ni),
      .clr_i  (lane_clr),
      .load_i (lane_ld[i]),
      .byte_i (in_data_i),
      .byte_o (lane_byte[i]),
      .fill_o (lane_fill[i])
    );
  end

  assign wr_req.addr = addr_q;
  assign wr_req.data = lane_byte;
  assign wr_req.mask = lane_fill;

  // State register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state_q <= S_IDLE;
    else         state_q <= state_d;
  end

  // Next-state logic; a failed write ack aborts from any active state.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE, S_DONE, S_ERROR: if (start_ok) state_d = S_COLLECT;
      S_COLLECT: begin
        if (berr_ev)                 state_d = S_ERROR;
        else if (word_end)           state_d = S_WRITE;
        else if (drop && in_last_i)  state_d = S_DRAIN;
      end
      S_WRITE: begin
        if (berr_ev)  state_d = S_ERROR;
        else if (acc) state_d = last_q ? S_DRAIN : S_COLLECT;
      end
      S_DRAIN: begin
        if (berr_ev)               state_d = S_ERROR;
        else if (out_step == '0)   state_d = S_DONE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Load bookkeeping: byte count, write address, last/overflow/bus-error flags.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q  <= '0;
      addr_q <= '0;
      last_q <= 1'b0;
      ovf_q  <= 1'b0;
      berr_q <= 1'b0;
    end else if (start_ok) begin
      cnt_q  <= '0;
      addr_q <= BASE_ADDR;
      last_q <= 1'b0;
      ovf_q  <= 1'b0;
      berr_q <= 1'b0;
    end else begin
      if (take)               cnt_q  <= cnt_q + 17'd1;
      if (acc)                addr_q <= addr_q + 32'd4;
      if (take && in_last_i)  last_q <= 1'b1;
      if (drop)               ovf_q  <= 1'b1;
      if (berr_ev)            berr_q <= 1'b1;
    end
  end

  // Writes accepted but not yet acknowledged; stray acks at zero are ignored.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni)       out_q <= '0;
    else if (start_ok) out_q <= '0;
    else               out_q <= out_step;
  end

`ifdef TCM_LOADER_CHECKSUM_EN
  logic [31:0] csum_q;

  // Running sum of every word the TCM accepted during this load.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni)       csum_q <= '0;
    else if (start_ok) csum_q <= '0;
    else if (acc)      csum_q <= csum_q + wr_req.data;
  end

  assign checksum_o = csum_q;
`endif

  assign mem_d_addr_o       = wr_req.addr;
  assign mem_d_data_wr_o    = wr_req.data;
  assign mem_d_wr_o         = req ? wr_req.mask : 4'b0000;
  assign mem_d_rd_o         = 1'b0;
  assign mem_d_req_tag_o    = '0;
  assign mem_d_cacheable_o  = 1'b0;
  assign mem_d_invalidate_o = 1'b0;
  assign mem_d_writeback_o  = 1'b0;
  assign mem_d_flush_o      = 1'b0;

  // The core only leaves reset after a clean load.
  assign core_rst_o   = !(state_q == S_DONE && !ovf_q && !berr_q);
  assign busy_o       = (state_q == S_COLLECT) || (state_q == S_WRITE) ||
                        (state_q == S_DRAIN);
  assign done_o       = (state_q == S_DONE);
  assign error_o      = ovf_q || berr_q;
  assign byte_count_o = cnt_q;

endmodule
